// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Brief    : Shared write-back select and MEM-stage FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Brief    : MEM/WB pipeline register; a stall loads a bubble (write disabled).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        reg_write,
    input  logic [4:0]  write_register,
    input  logic [31:0] write_data,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_Write_register,
    output logic [31:0] WB_Write_data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WB_RegWrite       <= 1'b0;
            WB_Write_register <= 5'd0;
            WB_Write_data     <= 32'd0;
        end else if (stall) begin
            WB_RegWrite       <= 1'b0;
        end else begin
            WB_RegWrite       <= reg_write;
            WB_Write_register <= write_register;
            WB_Write_data     <= write_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MIPS MEM stage: req/ack data-bus access, pipeline stall, MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic [31:0] MEM_Data_in2,
    input  logic [31:0] MEM_PC_plus_4,
    input  logic [4:0]  MEM_Write_register,
    input  logic [31:0] MEM_ALU_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        addr_error,
    output logic        bus_error,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_Write_register,
    output logic [31:0] WB_Write_data
);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_rdata;
    logic             r_load_err;

    logic             w_acc;
    logic             w_misaligned;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_wb_data;
    logic             w_wb_we;

    assign w_acc        = MEM_MemRead | MEM_MemWrite;
    assign w_misaligned = (MEM_ALU_out[1:0] != 2'b00);
    assign w_cnt_next   = r_wait_cnt + CNT_W'(1);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    // Combinational so the upstream stages freeze in the same cycle the access is seen.
    assign mem_stall = !reset && (((r_state == IDLE) && w_acc) || (r_state == REQ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_rdata    <= 32'd0;
            r_load_err <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_wdata <= 32'd0;
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_wait_cnt <= '0;
                        if (w_misaligned) begin
                            addr_error <= 1'b1;
                            r_load_err <= MEM_MemRead;
                            r_rdata    <= 32'd0;
                            r_state    <= DONE;
                        end else begin
                            dbus_req   <= 1'b1;
                            dbus_we    <= MEM_MemWrite;
                            dbus_addr  <= MEM_ALU_out;
                            dbus_wdata <= MEM_Data_in2;
                            r_state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    r_wait_cnt <= w_cnt_next;
                    // An ack in the timeout cycle still completes the access.
                    if (dbus_ack) begin
                        r_rdata  <= dbus_rdata;
                        dbus_req <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        dbus_req   <= 1'b0;
                        bus_error  <= 1'b1;
                        r_load_err <= MEM_MemRead;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    // EX/MEM advances this edge, so the same access is never reissued.
                    r_load_err <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_wb_data = MEM_ALU_out;
        case (MEM_MemtoReg)
            WB_SEL_MEM: w_wb_data = r_rdata;
            WB_SEL_PC4: w_wb_data = MEM_PC_plus_4;
            default:    w_wb_data = MEM_ALU_out;
        endcase
    end

    assign w_wb_we = MEM_RegWrite & ~r_load_err;

    mem_wb_reg u_mem_wb_reg (
        .clk               (clk),
        .reset             (reset),
        .stall             (mem_stall),
        .reg_write         (w_wb_we),
        .write_register    (MEM_Write_register),
        .write_data        (w_wb_data),
        .WB_RegWrite       (WB_RegWrite),
        .WB_Write_register (WB_Write_register),
        .WB_Write_data     (WB_Write_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed self-checking bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
    logic [1:0]  MEM_MemtoReg;
    logic [31:0] MEM_Data_in2, MEM_PC_plus_4, MEM_ALU_out;
    logic [4:0]  MEM_Write_register;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    logic        dbus_req, dbus_we, mem_stall, addr_error, bus_error, WB_RegWrite;
    logic [31:0] dbus_addr, dbus_wdata, WB_Write_data;
    logic [4:0]  WB_Write_register;

    logic        t_dbus_req, t_dbus_we, t_mem_stall, t_addr_error, t_bus_error, t_WB_RegWrite;
    logic [31:0] t_dbus_addr, t_dbus_wdata, t_WB_Write_data;
    logic [4:0]  t_WB_Write_register;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_Data_in2(MEM_Data_in2), .MEM_PC_plus_4(MEM_PC_plus_4),
        .MEM_Write_register(MEM_Write_register), .MEM_ALU_out(MEM_ALU_out),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .addr_error(addr_error), .bus_error(bus_error),
        .WB_RegWrite(WB_RegWrite), .WB_Write_register(WB_Write_register), .WB_Write_data(WB_Write_data)
    );

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
        .clk(clk), .reset(reset),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_Data_in2(MEM_Data_in2), .MEM_PC_plus_4(MEM_PC_plus_4),
        .MEM_Write_register(MEM_Write_register), .MEM_ALU_out(MEM_ALU_out),
        .dbus_req(t_dbus_req), .dbus_we(t_dbus_we), .dbus_addr(t_dbus_addr), .dbus_wdata(t_dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_stall(t_mem_stall), .addr_error(t_addr_error), .bus_error(t_bus_error),
        .WB_RegWrite(t_WB_RegWrite), .WB_Write_register(t_WB_Write_register), .WB_Write_data(t_WB_Write_data)
    );

    task automatic set_instr(input logic rd, input logic wr, input logic regw, input logic [1:0] m2r,
                             input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc4,
                             input logic [4:0] rdst);
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_RegWrite = regw; MEM_MemtoReg = m2r;
        MEM_ALU_out = alu; MEM_Data_in2 = d2; MEM_PC_plus_4 = pc4; MEM_Write_register = rdst;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_instr(0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        dbus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one held instruction through an instance until its stall drops, acking
    // on REQ cycle ack_on (0 = never), then lets the MEM/WB load edge pass.
    task automatic run_mem(input bit use_to, input int ack_on, input logic exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           output int stalls, output int reqs, output int field_bad,
                           output int aerr, output int berr);
        logic st, rq, we, ae, be;
        logic [31:0] ad, wd;
        stalls = 0; reqs = 0; field_bad = 0; aerr = 0; berr = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            st = use_to ? t_mem_stall  : mem_stall;
            rq = use_to ? t_dbus_req   : dbus_req;
            we = use_to ? t_dbus_we    : dbus_we;
            ad = use_to ? t_dbus_addr  : dbus_addr;
            wd = use_to ? t_dbus_wdata : dbus_wdata;
            ae = use_to ? t_addr_error : addr_error;
            be = use_to ? t_bus_error  : bus_error;
            if (st) stalls++;
            if (rq) begin
                reqs++;
                if (we !== exp_we || ad !== exp_addr || wd !== exp_wdata) field_bad++;
            end
            if (ae) aerr++;
            if (be) berr++;
            dbus_ack = rq && (reqs == ack_on);
            if (!st) break;
            @(negedge clk);
        end
        dbus_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_instr(1, 0, 1, 2'b01, 32'h100, 32'h0, 32'h0, 5'd3);
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        n_cmp++; if (dbus_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", dbus_req); end
        n_cmp++; if ({dbus_we, dbus_addr, dbus_wdata} !== 65'd0) begin n_bad++; $display("FAIL reset_bus: got %b %h %h want 0", dbus_we, dbus_addr, dbus_wdata); end
        n_cmp++; if ({addr_error, bus_error} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", addr_error, bus_error); end
        n_cmp++; if ({WB_RegWrite, WB_Write_register, WB_Write_data} !== 38'd0) begin n_bad++; $display("FAIL reset_wb: got %b %h %h want 0", WB_RegWrite, WB_Write_register, WB_Write_data); end
    endtask

    task automatic test_alu();
        do_reset();
        set_instr(0, 0, 1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5);
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
        @(negedge clk);
        n_cmp++; if (WB_Write_data !== 32'h1234) begin n_bad++; $display("FAIL alu_data: got %h want 00001234", WB_Write_data); end
        n_cmp++; if ({WB_RegWrite, WB_Write_register} !== {1'b1, 5'd5}) begin n_bad++; $display("FAIL alu_wr: got %b/%0d want 1/5", WB_RegWrite, WB_Write_register); end
        set_instr(0, 0, 1, 2'b10, 32'h1234, 32'h0, 32'h0040_0008, 5'd31);
        @(negedge clk);
        n_cmp++; if ({WB_Write_register, WB_Write_data} !== {5'd31, 32'h0040_0008}) begin n_bad++; $display("FAIL pc4_sel: got %0d/%h want 31/00400008", WB_Write_register, WB_Write_data); end
        set_instr(0, 0, 1, 2'b11, 32'h5678, 32'h0, 32'h0040_000C, 5'd0);
        @(negedge clk);
        n_cmp++; if ({WB_RegWrite, WB_Write_register, WB_Write_data} !== {1'b1, 5'd0, 32'h5678}) begin n_bad++; $display("FAIL sel11_r0: got %b/%0d/%h want 1/0/00005678", WB_RegWrite, WB_Write_register, WB_Write_data); end
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        dbus_ack = 1'b1;
        #1;
        n_cmp++; if ({mem_stall, dbus_req} !== 2'b00) begin n_bad++; $display("FAIL idle_ack: got stall=%b req=%b want 0 0", mem_stall, dbus_req); end
        @(negedge clk);
        dbus_ack = 1'b0;
        n_cmp++; if ({dbus_req, WB_RegWrite} !== 2'b00) begin n_bad++; $display("FAIL idle_ack_after: got req=%b we=%b want 0 0", dbus_req, WB_RegWrite); end
    endtask

    task automatic test_load();
        int st, rq, bad, ae, be;
        do_reset();
        dbus_rdata = 32'hCAFEF00D;
        set_instr(1, 0, 1, 2'b01, 32'h100, 32'h0, 32'h0, 5'd7);
        run_mem(0, 1, 1'b0, 32'h100, 32'h0, st, rq, bad, ae, be);
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL load_stall: got %0d want 2", st); end
        n_cmp++; if (rq !== 1 || bad !== 0) begin n_bad++; $display("FAIL load_req: got %0d cycles, %0d bad want 1, 0", rq, bad); end
        n_cmp++; if (WB_Write_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL load_data: got %h want cafef00d", WB_Write_data); end
        n_cmp++; if ({WB_RegWrite, WB_Write_register} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL load_wr: got %b/%0d want 1/7", WB_RegWrite, WB_Write_register); end
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_store();
        int st, rq, bad, ae, be;
        do_reset();
        dbus_rdata = 32'h1111_2222;
        set_instr(0, 1, 0, 2'b00, 32'h200, 32'hA5A5A5A5, 32'h0, 5'd0);
        run_mem(0, 5, 1'b1, 32'h200, 32'hA5A5A5A5, st, rq, bad, ae, be);
        n_cmp++; if (st !== 6) begin n_bad++; $display("FAIL store_stall: got %0d want 6", st); end
        n_cmp++; if (rq !== 5 || bad !== 0) begin n_bad++; $display("FAIL store_req: got %0d cycles, %0d bad want 5, 0", rq, bad); end
        n_cmp++; if (WB_RegWrite !== 1'b0) begin n_bad++; $display("FAIL store_wb: got %b want 0", WB_RegWrite); end
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_misaligned();
        int st, rq, bad, ae, be;
        do_reset();
        dbus_rdata = 32'hDEAD_BEEF;
        set_instr(1, 0, 1, 2'b01, 32'h102, 32'h0, 32'h0, 5'd9);
        run_mem(0, 1, 1'b0, 32'h102, 32'h0, st, rq, bad, ae, be);
        n_cmp++; if ({st, rq, ae} !== {32'd1, 32'd0, 32'd1}) begin n_bad++; $display("FAIL misalign_seq: got stall=%0d req=%0d aerr=%0d want 1 0 1", st, rq, ae); end
        n_cmp++; if ({WB_RegWrite, WB_Write_data} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL misalign_wb: got %b/%h want 0/00000000", WB_RegWrite, WB_Write_data); end
        n_cmp++; if (addr_error !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: got %b want 0", addr_error); end
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_timeout();
        int st, rq, bad, ae, be;
        do_reset();
        set_instr(1, 0, 1, 2'b01, 32'h300, 32'h0, 32'h0, 5'd3);
        run_mem(1, 0, 1'b0, 32'h300, 32'h0, st, rq, bad, ae, be);
        n_cmp++; if ({st, rq, be} !== {32'd5, 32'd4, 32'd1}) begin n_bad++; $display("FAIL timeout_seq: got stall=%0d req=%0d berr=%0d want 5 4 1", st, rq, be); end
        n_cmp++; if ({t_WB_RegWrite, t_bus_error, t_dbus_req} !== 3'b000) begin n_bad++; $display("FAIL timeout_after: got we=%b berr=%b req=%b want 000", t_WB_RegWrite, t_bus_error, t_dbus_req); end
        set_instr(0, 0, 1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd2);
        @(negedge clk);
        n_cmp++; if ({t_WB_RegWrite, t_WB_Write_data} !== {1'b1, 32'h77}) begin n_bad++; $display("FAIL timeout_resume: got %b/%h want 1/00000077", t_WB_RegWrite, t_WB_Write_data); end
        do_reset();
        dbus_rdata = 32'h0BAD_F00D;
        set_instr(1, 0, 1, 2'b01, 32'h304, 32'h0, 32'h0, 5'd4);
        run_mem(1, 4, 1'b0, 32'h304, 32'h0, st, rq, bad, ae, be);
        n_cmp++; if ({rq, be} !== {32'd4, 32'd0}) begin n_bad++; $display("FAIL ack_at_timeout: got req=%0d berr=%0d want 4 0", rq, be); end
        n_cmp++; if ({t_WB_RegWrite, t_WB_Write_data} !== {1'b1, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL ack_at_timeout_wb: got %b/%h want 1/0badf00d", t_WB_RegWrite, t_WB_Write_data); end
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        set_instr(0, 0, 1, 2'b00, 32'hFEED, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        set_instr(1, 0, 1, 2'b01, 32'h400, 32'h0, 32'h0, 5'd8);
        @(negedge clk);
        n_cmp++; if ({dbus_req, WB_Write_data} !== {1'b1, 32'hFEED}) begin n_bad++; $display("FAIL midreq_pre: got req=%b wb=%h want 1 0000feed", dbus_req, WB_Write_data); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({dbus_req, dbus_we, dbus_addr, mem_stall} !== 35'd0) begin n_bad++; $display("FAIL midreq_bus: got req=%b we=%b addr=%h stall=%b want 0", dbus_req, dbus_we, dbus_addr, mem_stall); end
        n_cmp++; if ({WB_RegWrite, WB_Write_register, WB_Write_data} !== 38'd0) begin n_bad++; $display("FAIL midreq_wb: got %b/%0d/%h want 0", WB_RegWrite, WB_Write_register, WB_Write_data); end
        @(negedge clk);
        reset = 1'b0;
        set_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dbus_ack = 1'b0;
        n_cmp++; if ({dbus_req, mem_stall, WB_RegWrite, WB_Write_data} !== 35'd0) begin n_bad++; $display("FAIL late_ack: got req=%b stall=%b we=%b wb=%h want 0", dbus_req, mem_stall, WB_RegWrite, WB_Write_data); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
